// File: rtl/cfg_ram_loader_if.sv
// Config-load bus bundle for cfg_ram_loader.
// Carries the 64-bit config word stream in and the SRAM write port and
// status strobes out. The loader uses the slave modport; whatever feeds the
// stream and consumes the writes uses the master modport.
interface cfg_ram_loader_if;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_ready;
  logic [6:0]  addr_wr;
  logic [7:0]  sram_sel;
  logic        wr_en;
  logic [63:0] din;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output s_valid, s_data,
    input  s_ready, addr_wr, sram_sel, wr_en, din, busy, done, err
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, addr_wr, sram_sel, wr_en, din, busy, done, err
  );
endinterface

// File: rtl/cfg_ram_loader.sv
// cfg_ram_loader: parses a 64-bit config stream made of blocks
// (header word followed by len_m1+1 data words) and writes each data word
// into the selected config SRAM at consecutive addresses, one cycle after
// the word is accepted.
// Optional feature macro: CFG_LOADER_CHKSUM_EN adds a trailing checksum
// word per block (XOR of all data words) checked in a CHK state.
// Without the macro the block ends on its last data word.
module cfg_ram_loader #(
  parameter int unsigned SRAM_NUM = 72,
  parameter logic [7:0]  MAGIC    = 8'hC5
) (
  input logic             clk,
  input logic             rst_n,
  cfg_ram_loader_if.slave bus
);

  localparam logic [8:0] SramLimit = 9'(SRAM_NUM);

`ifdef CFG_LOADER_CHKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
  } state_e;
`endif

  state_e      state_q,   state_d;
  logic        ready_q,   ready_d;
  logic [6:0]  addrPtr_q, addrPtr_d;
  logic [6:0]  count_q,   count_d;
  logic [7:0]  sel_q,     sel_d;
  logic        wrEn_q,    wrEn_d;
  logic [6:0]  addrWr_q,  addrWr_d;
  logic [7:0]  sramSel_q, sramSel_d;
  logic [63:0] din_q,     din_d;
  logic        done_q,    done_d;
  logic        err_q,     err_d;
`ifdef CFG_LOADER_CHKSUM_EN
  logic [63:0] chksum_q,  chksum_d;
`endif

  logic        accept;
  logic [7:0]  hdrTag;
  logic [6:0]  hdrLenM1;
  logic [6:0]  hdrBase;
  logic [7:0]  hdrSel;
  logic        hdrOk;

  assign accept   = bus.s_valid && ready_q;
  assign hdrTag   = bus.s_data[63:56];
  assign hdrLenM1 = bus.s_data[22:16];
  assign hdrBase  = bus.s_data[14:8];
  assign hdrSel   = bus.s_data[7:0];
  assign hdrOk    = (hdrTag == MAGIC) && ({1'b0, hdrSel} < SramLimit);

  assign bus.s_ready  = ready_q;
  assign bus.wr_en    = wrEn_q;
  assign bus.addr_wr  = addrWr_q;
  assign bus.sram_sel = sramSel_q;
  assign bus.din      = din_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);

  // Next-state and registered-output logic: header parse, data write, checksum compare.
  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b1;
    addrPtr_d = addrPtr_q;
    count_d   = count_q;
    sel_d     = sel_q;
    wrEn_d    = 1'b0;
    addrWr_d  = addrWr_q;
    sramSel_d = sramSel_q;
    din_d     = din_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef CFG_LOADER_CHKSUM_EN
    chksum_d  = chksum_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdrOk) begin
            sel_d     = hdrSel;
            addrPtr_d = hdrBase;
            count_d   = hdrLenM1;
`ifdef CFG_LOADER_CHKSUM_EN
            chksum_d  = 64'd0;
`endif
            state_d   = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      DATA: begin
        if (accept) begin
          wrEn_d    = 1'b1;
          din_d     = bus.s_data;
          addrWr_d  = addrPtr_q;
          sramSel_d = sel_q;
          addrPtr_d = addrPtr_q + 7'd1;
`ifdef CFG_LOADER_CHKSUM_EN
          chksum_d  = chksum_q ^ bus.s_data;
`endif
          if (count_q == 7'd0) begin
`ifdef CFG_LOADER_CHKSUM_EN
            state_d = CHK;
`else
            done_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - 7'd1;
          end
        end
      end

`ifdef CFG_LOADER_CHKSUM_EN
      CHK: begin
        if (accept) begin
          if (bus.s_data == chksum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      addrPtr_q <= 7'd0;
      count_q   <= 7'd0;
      sel_q     <= 8'd0;
      wrEn_q    <= 1'b0;
      addrWr_q  <= 7'd0;
      sramSel_q <= 8'd0;
      din_q     <= 64'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CFG_LOADER_CHKSUM_EN
      chksum_q  <= 64'd0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      addrPtr_q <= addrPtr_d;
      count_q   <= count_d;
      sel_q     <= sel_d;
      wrEn_q    <= wrEn_d;
      addrWr_q  <= addrWr_d;
      sramSel_q <= sramSel_d;
      din_q     <= din_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CFG_LOADER_CHKSUM_EN
      chksum_q  <= chksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_ram_loader.sv
// Testbench for cfg_ram_loader: table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written stall, mid-block reset
// and (when CFG_LOADER_CHKSUM_EN is defined) checksum sequences.
`timescale 1ns/1ps
module tb_cfg_ram_loader;

`ifdef CFG_LOADER_CHKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        wrEn;
    logic [6:0]  addr;
    logic [7:0]  sel;
    logic [63:0] din;
    logic        done;
    logic        err;
  } outs_t;

  typedef struct {
    logic        rstN;
    logic        valid;
    logic [63:0] data;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cfg_ram_loader_if bus ();

  cfg_ram_loader #(
    .SRAM_NUM(72),
    .MAGIC   (8'hC5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [63:0] H1 = 64'hC500_0000_0002_050C;
  localparam logic [63:0] H2 = 64'hC500_0000_0003_7E03;
  localparam logic [63:0] HBADTAG = 64'h0000_0000_0002_050C;
  localparam logic [63:0] HBADSEL = 64'hC500_0000_0000_0048;
  localparam logic [63:0] HSEL71  = 64'hC500_0000_0000_0047;
  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] DC = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D0 = 64'hDEAD_0000_0000_1000;
  localparam logic [63:0] D1 = 64'hBEEF_0000_0000_2001;
  localparam logic [63:0] D2 = 64'h0F0F_0000_0000_3002;
  localparam logic [63:0] D3 = 64'h7777_0000_0000_4003;
  localparam logic [63:0] DE = 64'hFEED_FACE_CAFE_BEEF;

  function automatic outs_t mk(input logic ready, input logic busy, input logic wrEn,
                               input logic [6:0] addr, input logic [7:0] sel,
                               input logic [63:0] din, input logic done, input logic err);
    outs_t o;
    o.ready = ready;
    o.busy  = busy;
    o.wrEn  = wrEn;
    o.addr  = addr;
    o.sel   = sel;
    o.din   = din;
    o.done  = done;
    o.err   = err;
    return o;
  endfunction

  task automatic addVec(input logic r, input logic v, input logic [63:0] d, input outs_t e);
    vec_t x;
    x.rstN  = r;
    x.valid = v;
    x.data  = d;
    x.exp   = e;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [63:0] d);
    rst_n       = r;
    bus.s_valid = v;
    bus.s_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input outs_t e);
    outs_t a;
    a = mk(bus.s_ready, bus.busy, bus.wr_en, bus.addr_wr, bus.sram_sel, bus.din, bus.done, bus.err);
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s: got ready=%0b busy=%0b wr_en=%0b addr=%0d sel=%0d din=%h done=%0b err=%0b; want ready=%0b busy=%0b wr_en=%0b addr=%0d sel=%0d din=%h done=%0b err=%0b",
               name, a.ready, a.busy, a.wrEn, a.addr, a.sel, a.din, a.done, a.err,
               e.ready, e.busy, e.wrEn, e.addr, e.sel, e.din, e.done, e.err);
    end
  endtask

  task automatic step(input string name, input logic r, input logic v,
                      input logic [63:0] d, input outs_t e);
    applyStimulus(r, v, d);
    checkOutput(name, e);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 64'd0;
    @(negedge clk);

    // reset and ready
    addVec(1'b0, 1'b0, 64'd0, mk(0, 0, 0, 7'd0, 8'd0, 64'd0, 0, 0));
    addVec(1'b1, 1'b0, 64'd0, mk(1, 0, 0, 7'd0, 8'd0, 64'd0, 0, 0));
    // sel=12 base=5 three words
    addVec(1'b1, 1'b1, H1, mk(1, 1, 0, 7'd0, 8'd0, 64'd0, 0, 0));
    addVec(1'b1, 1'b1, DA, mk(1, 1, 1, 7'd5, 8'd12, DA, 0, 0));
    addVec(1'b1, 1'b1, DB, mk(1, 1, 1, 7'd6, 8'd12, DB, 0, 0));
    addVec(1'b1, 1'b1, DC, mk(1, CK, 1, 7'd7, 8'd12, DC, !CK, 0));
`ifdef CFG_LOADER_CHKSUM_EN
    addVec(1'b1, 1'b1, DA ^ DB ^ DC, mk(1, 0, 0, 7'd7, 8'd12, DC, 1, 0));
`endif
    // back-to-back header, address wrap 126,127,0,1
    addVec(1'b1, 1'b1, H2, mk(1, 1, 0, 7'd7, 8'd12, DC, 0, 0));
    addVec(1'b1, 1'b1, D0, mk(1, 1, 1, 7'd126, 8'd3, D0, 0, 0));
    addVec(1'b1, 1'b1, D1, mk(1, 1, 1, 7'd127, 8'd3, D1, 0, 0));
    addVec(1'b1, 1'b1, D2, mk(1, 1, 1, 7'd0, 8'd3, D2, 0, 0));
    addVec(1'b1, 1'b1, D3, mk(1, CK, 1, 7'd1, 8'd3, D3, !CK, 0));
`ifdef CFG_LOADER_CHKSUM_EN
    addVec(1'b1, 1'b1, D0 ^ D1 ^ D2 ^ D3, mk(1, 0, 0, 7'd1, 8'd3, D3, 1, 0));
`endif
    // bad tag, bad sel, then good header with sel=71
    addVec(1'b1, 1'b1, HBADTAG, mk(1, 0, 0, 7'd1, 8'd3, D3, 0, 1));
    addVec(1'b1, 1'b0, 64'd0, mk(1, 0, 0, 7'd1, 8'd3, D3, 0, 0));
    addVec(1'b1, 1'b1, HBADSEL, mk(1, 0, 0, 7'd1, 8'd3, D3, 0, 1));
    addVec(1'b1, 1'b1, HSEL71, mk(1, 1, 0, 7'd1, 8'd3, D3, 0, 0));
    addVec(1'b1, 1'b1, DE, mk(1, CK, 1, 7'd0, 8'd71, DE, !CK, 0));
`ifdef CFG_LOADER_CHKSUM_EN
    addVec(1'b1, 1'b1, DE, mk(1, 0, 0, 7'd0, 8'd71, DE, 1, 0));
`endif
    addVec(1'b1, 1'b0, 64'd0, mk(1, 0, 0, 7'd0, 8'd71, DE, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // stall: s_valid 1-0-0-1-1, sel=1 base=10 three words
    step("stall_hdr", 1, 1, 64'hC500_0000_0002_0A01, mk(1, 1, 0, 7'd0, 8'd71, DE, 0, 0));
    step("stall_w0",  1, 1, 64'h5A5A_0000_0000_0000, mk(1, 1, 1, 7'd10, 8'd1, 64'h5A5A_0000_0000_0000, 0, 0));
    step("stall_gap1", 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, mk(1, 1, 0, 7'd10, 8'd1, 64'h5A5A_0000_0000_0000, 0, 0));
    step("stall_gap2", 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, mk(1, 1, 0, 7'd10, 8'd1, 64'h5A5A_0000_0000_0000, 0, 0));
    step("stall_w1",  1, 1, 64'h5A5A_0000_0000_0001, mk(1, 1, 1, 7'd11, 8'd1, 64'h5A5A_0000_0000_0001, 0, 0));
    step("stall_w2",  1, 1, 64'h5A5A_0000_0000_0002, mk(1, CK, 1, 7'd12, 8'd1, 64'h5A5A_0000_0000_0002, !CK, 0));
`ifdef CFG_LOADER_CHKSUM_EN
    step("stall_chk", 1, 1, 64'h5A5A_0000_0000_0003, mk(1, 0, 0, 7'd12, 8'd1, 64'h5A5A_0000_0000_0002, 1, 0));
`endif

    // reset after 2 of 4 words (sel=2 base=20); reset wins over a same-cycle handshake
    step("rst_hdr", 1, 1, 64'hC500_0000_0003_1402, mk(1, 1, 0, 7'd12, 8'd1, 64'h5A5A_0000_0000_0002, 0, 0));
    step("rst_w0",  1, 1, 64'h3333_0000_0000_0000, mk(1, 1, 1, 7'd20, 8'd2, 64'h3333_0000_0000_0000, 0, 0));
    step("rst_w1",  1, 1, 64'h3333_0000_0000_0001, mk(1, 1, 1, 7'd21, 8'd2, 64'h3333_0000_0000_0001, 0, 0));
    step("rst_cyc", 0, 1, 64'h3333_0000_0000_0002, mk(0, 0, 0, 7'd0, 8'd0, 64'd0, 0, 0));
    step("rst_rel", 1, 0, 64'd0, mk(1, 0, 0, 7'd0, 8'd0, 64'd0, 0, 0));
    step("rst_hdr2", 1, 1, 64'hC500_0000_0000_0005, mk(1, 1, 0, 7'd0, 8'd0, 64'd0, 0, 0));
    step("rst_w", 1, 1, 64'h4444_0000_0000_0004, mk(1, CK, 1, 7'd0, 8'd5, 64'h4444_0000_0000_0004, !CK, 0));
`ifdef CFG_LOADER_CHKSUM_EN
    step("rst_chk", 1, 1, 64'h4444_0000_0000_0004, mk(1, 0, 0, 7'd0, 8'd5, 64'h4444_0000_0000_0004, 1, 0));

    // checksum good (1^2=3) then bad (0), writes performed either way
    step("ck_hdr",  1, 1, 64'hC500_0000_0001_0000, mk(1, 1, 0, 7'd0, 8'd5, 64'h4444_0000_0000_0004, 0, 0));
    step("ck_w1",   1, 1, 64'd1, mk(1, 1, 1, 7'd0, 8'd0, 64'd1, 0, 0));
    step("ck_w2",   1, 1, 64'd2, mk(1, 1, 1, 7'd1, 8'd0, 64'd2, 0, 0));
    step("ck_good", 1, 1, 64'd3, mk(1, 0, 0, 7'd1, 8'd0, 64'd2, 1, 0));
    step("ck_hdrb", 1, 1, 64'hC500_0000_0001_0000, mk(1, 1, 0, 7'd1, 8'd0, 64'd2, 0, 0));
    step("ck_w1b",  1, 1, 64'd1, mk(1, 1, 1, 7'd0, 8'd0, 64'd1, 0, 0));
    step("ck_w2b",  1, 1, 64'd2, mk(1, 1, 1, 7'd1, 8'd0, 64'd2, 0, 0));
    step("ck_bad",  1, 1, 64'd0, mk(1, 0, 0, 7'd1, 8'd0, 64'd2, 0, 1));
`endif
    step("idle_end", 1, 0, 64'd0, mk(1, 0, 0, CK ? 7'd1 : 7'd0, CK ? 8'd0 : 8'd5,
                                     CK ? 64'd2 : 64'h4444_0000_0000_0004, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
